jtcps1_snd_post: RTL
====================

# jtcps1_snd_post

Stereo audio post-processor placed directly downstream of the CPS1 sound subsystem mixer outputs (`left`, `right`, `sample`). For each input sample it removes DC offset with a first-order leaky DC estimator, saturates the result to 16 bits, and flags clipping. It also maintains decaying peak meters for the OSD and debug bus. One shared arithmetic datapath is time-multiplexed between channels by a small FSM.

## Interface
- `K`, default 9: DC estimator shift; the corner is ≈ fs/(2π·2^K), about 17 Hz at 55.9 kHz.
- `PKDIV`, default 10: the peak meters decay by 1 every 2^PKDIV output samples.
- `rst`  in  1: asynchronous, active-high reset.
- `clk`  in  1: 48 MHz system clock. Single clock domain.
- `sample`  in  1: one-cycle strobe that marks new `left_in` and `right_in` values.
- `left_in`, `right_in`  in  16: signed mixer output.
- `enable`  in  1: 1 = DC removal on; 0 = bypass.
- `clr`  in  1: synchronous clear of `clip_l`, `clip_r` and `overrun`.
- `left`, `right`  out  16: signed processed output, registered.
- `sample_out`  out  1: one-cycle strobe when `left` and `right` update.
- `clip_l`, `clip_r`  out  1: sticky saturation flags.
- `overrun`  out  1: sticky flag; a `sample` strobe arrived while the FSM was busy.
- `peak_l`, `peak_r`  out  8: peak magnitude meters.

## Operation
- FSM states and transitions:
  - IDLE → CAPT when `sample`=1 is seen at an edge. On that edge `left_in` and `right_in` are registered.
  - CAPT → LEFT → RIGHT → IDLE. Each step is one clock.
- State: `dc_l` and `dc_r`, each signed 16+K bits. Each holds the DC estimate ×2^K. Reset value is 0.
- Per channel, with x = captured input and d = dc >>> K (arithmetic shift, floor):
  - y17 = x − d, computed at 17 bits, using the dc value before its update.
  - dc ← dc + x − d. This cannot overflow at 16+K bits.
  - out = saturate(y17) to [−32768, 32767]. If saturation occurs, set that channel's clip flag.
- The LEFT state computes the left channel and RIGHT computes the right channel. Both use the same adder/saturator.
- When `enable`=0:
  - y17 = x, so out = x, and no clip is possible.
  - The dc registers are cleared to 0.
  - Latency is unchanged.
- Peak meters, updated in RIGHT alongside the outputs:
  - mag = min(|out| >> 7, 255). |−32768| maps to 255.
  - If mag > peak, then peak ← mag.
  - Otherwise, if the decay tick is active and peak > 0, then peak ← peak − 1.
  - The decay tick comes from a PKDIV-bit counter of output samples; it is active when the counter wraps to 0.
- Overrun: `sample`=1 in any state other than IDLE sets `overrun`. That strobe is dropped and the FSM sequence continues undisturbed.
- `clr`:
  - Clears the sticky flags on the edge it is sampled.
  - If a set and `clr` happen in the same cycle, the set wins.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - A sample in flight is discarded and no `sample_out` is issued for it.

## Timing
- Reset values: `left`, `right`, `peak_l`, `peak_r` = 0. `sample_out`, `clip_l`, `clip_r`, `overrun` = 0. dc registers = 0, decay counter = 0, state = IDLE.
- Edge E0: `sample` is high; inputs are captured.
- Edge E1: CAPT.
- Edge E2: `left` is written.
- Edge E3: `right` and both peaks are written, and `sample_out` is registered high.
- After E3: `sample_out` is high for exactly the one cycle that follows E3, and both outputs are valid from that cycle on.
- Latency from the `sample` strobe to `sample_out` is 4 cycles. The minimum input strobe spacing is 4 cycles; a strobe at E0+4 is accepted.
- At system rates, `sample` arrives about 860 cycles apart, so overrun indicates an upstream fault.

## Test plan
- DC step:
  - Stimulus: `enable`=1, constant input 0x1000 on both channels.
  - Required: first `left` = 0x1000. After 512 samples, `left` is within 0x05D0–0x05F0. After 16384 samples, `left` = 0.
- Bypass:
  - Stimulus: `enable`=0 with random inputs.
  - Required: `left` = `left_in` and `right` = `right_in` for every sample. `sample_out` is high 4 cycles after each `sample`. dc registers read 0.
- Saturation:
  - Stimulus: settle with input −0x7000 for 20000 samples, then step to +0x7FFF.
  - Required: `left` = 0x7FFF and `clip_l`=1, while `clip_r` stays 0 if `right_in` was held at 0.
  - Follow-up: `clr` pulse → `clip_l`=0.
- Overrun:
  - Stimulus: `sample` at E0 and again at E0+2.
  - Required: `overrun`=1 and exactly one `sample_out`.
  - Follow-up: a strobe at E0+4 is processed normally.
- Peak decay:
  - Stimulus: `enable`=0, PKDIV=2. One sample of 0x7FFF, then zeros.
  - Required: `peak_l`=255, then it decreases by 1 every 4 output samples and holds at 0.
- Reset mid-operation:
  - Stimulus: assert `rst` at E1.
  - Required: all outputs are 0 at once, there is no `sample_out`, and the next `sample` after release yields `left` = x, with dc restarted from 0.

Source files
------------

// File: rtl/jtcps1_snd_post.sv
// jtcps1_snd_post
// ---------------
// Stereo post-processor for the CPS1 sound mixer outputs. Every accepted
// sample strobe captures both channels, then one shared subtract/saturate
// datapath processes the left channel and then the right channel. Each
// channel removes DC with a leaky first-order estimator, clamps to 16 bits
// and raises a sticky clip flag on saturation. Decaying 8-bit peak meters
// follow the magnitude of the outputs.
//
// Parameters:
//   K       DC estimator shift (corner ~ fs / (2*pi*2^K))
//   PKDIV   peak meters decay by one every 2^PKDIV output samples
//
// Ports:
//   rst            asynchronous active-high reset
//   clk            system clock
//   sample         one-cycle strobe marking new left_in/right_in
//   left_in        signed 16-bit left mixer output
//   right_in       signed 16-bit right mixer output
//   enable         1 = DC removal active, 0 = bypass (dc estimates cleared)
//   clr            synchronous clear of clip_l, clip_r and overrun
//   left, right    registered signed processed outputs
//   sample_out     one-cycle strobe when left/right have been updated
//   clip_l/clip_r  sticky saturation flags
//   overrun        sticky flag: strobe arrived while busy (strobe dropped)
//   peak_l/peak_r  decaying peak magnitude meters
module jtcps1_snd_post #(
    parameter int K     = 9,
    parameter int PKDIV = 10
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        sample,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        enable,
    input  logic        clr,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        sample_out,
    output logic        clip_l,
    output logic        clip_r,
    output logic        overrun,
    output logic [7:0]  peak_l,
    output logic [7:0]  peak_r
);

    localparam int DW = 16 + K;

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        LEFT,
        RIGHT
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       xl_q, xl_d, xr_q, xr_d;
    logic [DW-1:0]     dcl_q, dcl_d, dcr_q, dcr_d;
    logic [15:0]       left_q, left_d, right_q, right_d;
    logic [7:0]        peak_l_q, peak_l_d, peak_r_q, peak_r_d;
    logic [PKDIV-1:0]  cnt_q, cnt_d;
    logic              so_q, so_d;
    logic              clip_l_q, clip_l_d, clip_r_q, clip_r_d;
    logic              ovr_q, ovr_d;

    logic [15:0]       x_sel;
    logic [DW-1:0]     dc_sel;
    logic [15:0]       d16;
    logic [16:0]       y17;
    logic [DW-1:0]     dc_next;
    logic [15:0]       sat;
    logic              sat_hit;
    logic              tick;

    // Magnitude for the meters: |v| >> 7, with |-32768| forced to 255.
    function automatic logic [7:0] magOf(input logic [15:0] v);
        logic [16:0] a;
        a = v[15] ? (17'd0 - {1'b1, v}) : {1'b0, v};
        return (a[16:15] != 2'b00) ? 8'hFF : 8'(a >> 7);
    endfunction

    // A louder sample always captures the meter; otherwise it may decay.
    function automatic logic [7:0] peakNext(input logic [7:0] pk,
                                            input logic [7:0] mag,
                                            input logic       dec);
        if (mag > pk)
            return mag;
        else if (dec && pk != 8'd0)
            return pk - 8'd1;
        else
            return pk;
    endfunction

    // Shared arithmetic: the channel is picked by the FSM state. The DC
    // estimate's integer part is simply its top 16 bits (floor shift), and
    // the difference is formed at 17 bits so saturation can be detected as
    // a disagreement between the two top bits.
    always_comb begin
        x_sel   = (state_q == RIGHT) ? xr_q  : xl_q;
        dc_sel  = (state_q == RIGHT) ? dcr_q : dcl_q;
        d16     = dc_sel[DW-1:K];
        y17     = enable ? ({x_sel[15], x_sel} - {d16[15], d16})
                         : {x_sel[15], x_sel};
        dc_next = enable ? (dc_sel + {{(K-1){y17[16]}}, y17}) : '0;
        sat_hit = y17[16] ^ y17[15];
        if (sat_hit)
            sat = y17[16] ? 16'h8000 : 16'h7FFF;
        else
            sat = y17[15:0];
        tick    = &cnt_q;
    end

    // Sequencer and register next-state. A strobe is only accepted in IDLE;
    // anywhere else it is dropped and flagged. Flag clears are applied first
    // so that a set in the same cycle overrides the clear.
    always_comb begin
        state_d  = state_q;
        xl_d     = xl_q;
        xr_d     = xr_q;
        dcl_d    = dcl_q;
        dcr_d    = dcr_q;
        left_d   = left_q;
        right_d  = right_q;
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        cnt_d    = cnt_q;
        so_d     = 1'b0;
        clip_l_d = clr ? 1'b0 : clip_l_q;
        clip_r_d = clr ? 1'b0 : clip_r_q;
        ovr_d    = clr ? 1'b0 : ovr_q;

        if (sample && state_q != IDLE)
            ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (sample) begin
                    xl_d    = left_in;
                    xr_d    = right_in;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                state_d = LEFT;
            end
            LEFT: begin
                left_d  = sat;
                dcl_d   = dc_next;
                if (sat_hit)
                    clip_l_d = 1'b1;
                state_d = RIGHT;
            end
            RIGHT: begin
                right_d  = sat;
                dcr_d    = dc_next;
                if (sat_hit)
                    clip_r_d = 1'b1;
                peak_l_d = peakNext(peak_l_q, magOf(left_q), tick);
                peak_r_d = peakNext(peak_r_q, magOf(sat), tick);
                cnt_d    = cnt_q + {{(PKDIV-1){1'b0}}, 1'b1};
                so_d     = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any sample in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            xl_q     <= '0;
            xr_q     <= '0;
            dcl_q    <= '0;
            dcr_q    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            peak_l_q <= '0;
            peak_r_q <= '0;
            cnt_q    <= '0;
            so_q     <= 1'b0;
            clip_l_q <= 1'b0;
            clip_r_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            xl_q     <= xl_d;
            xr_q     <= xr_d;
            dcl_q    <= dcl_d;
            dcr_q    <= dcr_d;
            left_q   <= left_d;
            right_q  <= right_d;
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
            cnt_q    <= cnt_d;
            so_q     <= so_d;
            clip_l_q <= clip_l_d;
            clip_r_q <= clip_r_d;
            ovr_q    <= ovr_d;
        end
    end

    assign left       = left_q;
    assign right      = right_q;
    assign sample_out = so_q;
    assign clip_l     = clip_l_q;
    assign clip_r     = clip_r_q;
    assign overrun    = ovr_q;
    assign peak_l     = peak_l_q;
    assign peak_r     = peak_r_q;

endmodule
